// File: rtl/spi_instr_loader_if.sv
// SPI pin and regfile write-port bundle for spi_instr_loader.
// The slave modport is the loader's view; the master modport is the SPI host/regfile side.
interface spi_instr_loader_if #(
  parameter int unsigned INSTR_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH  = 5
);
  logic                   spi_sclk;
  logic                   spi_cs_n;
  logic                   spi_mosi;
  logic [INSTR_WIDTH-1:0] instr_data;
  logic [ADDR_WIDTH-1:0]  write_addr;
  logic                   write_en;
  logic                   busy;
  logic                   frame_err;

  modport slave (
    input  spi_sclk, spi_cs_n, spi_mosi,
    output instr_data, write_addr, write_en, busy, frame_err
  );

  modport master (
    output spi_sclk, spi_cs_n, spi_mosi,
    input  instr_data, write_addr, write_en, busy, frame_err
  );
endinterface

// File: rtl/spi_instr_loader.sv
// Oversampled SPI mode-0 slave that writes PIO instruction words into the regfile.
// Define SPI_AUTOINC_EN to allow burst writes with auto-incrementing address in one frame.
module spi_instr_loader #(
  parameter int unsigned INSTR_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic                clk,
  input logic                rst,
  spi_instr_loader_if.slave  bus
);

  localparam int unsigned CntW = $clog2(INSTR_WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StCmd, StData, StDiscard} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_dly_q, cs_dly_q;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, cs_fall, cs_rise, sample;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [INSTR_WIDTH-1:0] shift_q, shift_d, shift_in;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   wrote_q, wrote_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0]  waddr_q, waddr_d;
  logic                   we_q, we_d;
  logic                   ferr_q, ferr_d;

  // cs_n sync resets low so a chip select already asserted at reset release is not a frame start.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_dly_q  <= 1'b0;
      cs_dly_q    <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.spi_sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
      sclk_dly_q  <= sclk_sync_q[SYNC_STAGES-1];
      cs_dly_q    <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign cs_fall   = ~cs_s & cs_dly_q;
  assign cs_rise   = cs_s & ~cs_dly_q;
  assign sample    = sclk_rise & ~cs_s;
  assign shift_in  = {shift_q[INSTR_WIDTH-2:0], mosi_s};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shift_q <= '0;
      addr_q  <= '0;
      wrote_q <= 1'b0;
      instr_q <= '0;
      waddr_q <= '0;
      we_q    <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      addr_q  <= addr_d;
      wrote_q <= wrote_d;
      instr_q <= instr_d;
      waddr_q <= waddr_d;
      we_q    <= we_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    addr_d  = addr_q;
    wrote_d = wrote_q;
    instr_d = instr_q;
    waddr_d = waddr_q;
    we_d    = 1'b0;
    ferr_d  = 1'b0;
    // A cs_n rise takes priority; any SCLK rise in the same cycle is dropped.
    if (cs_rise) begin
      state_d = StIdle;
      ferr_d  = (state_q == StCmd) ||
                ((state_q == StData) && ((cnt_q != '0) || !wrote_q));
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cs_fall) begin
            state_d = StCmd;
            cnt_d   = '0;
            shift_d = '0;
            wrote_d = 1'b0;
          end
        end
        StCmd: begin
          if (sample) begin
            shift_d = shift_in;
            cnt_d   = cnt_q + CntW'(1);
            if (cnt_q == CntW'(7)) begin
              cnt_d = '0;
              if (shift_q[6]) begin
                state_d = StData;
                addr_d  = shift_in[ADDR_WIDTH-1:0];
              end else begin
                state_d = StDiscard;
              end
            end
          end
        end
        StData: begin
          if (sample) begin
            shift_d = shift_in;
            cnt_d   = cnt_q + CntW'(1);
            if (cnt_q == CntW'(INSTR_WIDTH - 1)) begin
              instr_d = shift_in;
              waddr_d = addr_q;
              we_d    = 1'b1;
              wrote_d = 1'b1;
              cnt_d   = '0;
`ifdef SPI_AUTOINC_EN
              addr_d  = addr_q + ADDR_WIDTH'(1);
`else
              state_d = StDiscard;
`endif
            end
          end
        end
        StDiscard: ;
        default: state_d = StIdle;
      endcase
    end
  end

  assign bus.instr_data = instr_q;
  assign bus.write_addr = waddr_q;
  assign bus.write_en   = we_q;
  assign bus.busy       = (state_q != StIdle);
  assign bus.frame_err  = ferr_q;

endmodule

// File: tb/tb_spi_instr_loader.sv
// Directed bench for spi_instr_loader: frame-level write/error model plus literal pins.
// Honours SPI_AUTOINC_EN the same way as the design.
module tb_spi_instr_loader;

`ifdef SPI_AUTOINC_EN
  localparam bit AutoInc = 1'b1;
`else
  localparam bit AutoInc = 1'b0;
`endif

  typedef struct {
    logic [4:0]  a;
    logic [15:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  spi_instr_loader_if #(.INSTR_WIDTH(16), .ADDR_WIDTH(5)) bus ();

  spi_instr_loader #(
    .INSTR_WIDTH(16),
    .ADDR_WIDTH (5),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  wr_t         exp_q[$];
  logic [4:0]  last_addr = '0;
  logic [15:0] last_data = '0;
  int          wr_cnt = 0;
  int          err_cnt = 0;
  logic [4:0]  cap_addr = '0;
  logic [15:0] cap_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the queue of expected writes and the held output values.
  always @(negedge clk) begin
    if (!rst) begin
      last_addr = '0;
      last_data = '0;
    end else begin
      if (bus.write_en === 1'b1) begin
        wr_cnt++;
        cap_addr = bus.write_addr;
        cap_data = bus.instr_data;
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'(bus.write_en), 32'd0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          last_addr = e.a;
          last_data = e.d;
        end
      end
      check("held_addr", 32'(bus.write_addr), 32'(last_addr));
      check("held_data", 32'(bus.instr_data), 32'(last_data));
      if (bus.frame_err === 1'b1) err_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bit(input logic b);
    bus.spi_mosi = b;
    tick(3);
    bus.spi_sclk = 1'b1;
    tick(3);
    bus.spi_sclk = 1'b0;
  endtask

  // Model: derive the writes and error outcome of a whole frame, then drive it.
  task automatic frame(input logic [63:0] bits, input int n);
    logic [7:0]  cmd;
    logic [15:0] d;
    int          nw, rem, exp_err, e0;
    wr_t         w;
    exp_err = 0;
    if (n < 8) begin
      exp_err = 1;
    end else begin
      cmd = '0;
      for (int i = 0; i < 8; i++) cmd = {cmd[6:0], bits[n-1-i]};
      if (cmd[7]) begin
        nw  = (n - 8) / 16;
        rem = (n - 8) % 16;
        if (AutoInc) exp_err = (nw == 0 || rem != 0) ? 1 : 0;
        else begin
          exp_err = (nw == 0) ? 1 : 0;
          if (nw > 1) nw = 1;
        end
        for (int k = 0; k < nw; k++) begin
          d = '0;
          for (int j = 0; j < 16; j++) d = {d[14:0], bits[n-9-16*k-j]};
          w.a = 5'(int'(cmd[4:0]) + k);
          w.d = d;
          exp_q.push_back(w);
        end
      end
    end
    e0 = err_cnt;
    bus.spi_cs_n = 1'b0;
    tick(4);
    for (int i = n - 1; i >= 0; i--) spi_bit(bits[i]);
    tick(2);
    check("busy_in_frame", 32'(bus.busy), 32'd1);
    bus.spi_cs_n = 1'b1;
    tick(2);
    check("busy_before_idle", 32'(bus.busy), 32'd1);
    tick(1);
    check("busy_after_idle", 32'(bus.busy), 32'd0);
    tick(8);
    check("frame_err_count", 32'(err_cnt - e0), 32'(exp_err));
    check("pending_writes", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int w0, e0;
    bus.spi_sclk = 1'b0;
    bus.spi_cs_n = 1'b1;
    bus.spi_mosi = 1'b0;
    rst = 1'b0;
    tick(3);
    check("rst_instr_data", 32'(bus.instr_data), 32'd0);
    check("rst_write_addr", 32'(bus.write_addr), 32'd0);
    check("rst_write_en", 32'(bus.write_en), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_frame_err", 32'(bus.frame_err), 32'd0);
    rst = 1'b1;
    tick(6);

    // Single write
    w0 = wr_cnt;
    frame(64'({8'h83, 16'hA0C5}), 24);
    check("t1_write_count", 32'(wr_cnt - w0), 32'd1);
    check("t1_addr", 32'(cap_addr), 32'd3);
    check("t1_data", 32'(cap_data), 32'hA0C5);

    // Read command: nothing written, no error
    w0 = wr_cnt;
    frame(64'({8'h03, 16'hFFFF}), 24);
    check("t2_write_count", 32'(wr_cnt - w0), 32'd0);

    // Abort in DATA, then a clean write to addr 5
    e0 = err_cnt;
    frame(64'({8'h85, 7'h55}), 15);
    check("t3_abort_err", 32'(err_cnt - e0), 32'd1);
    frame(64'({8'h85, 16'h1234}), 24);
    check("t3_addr", 32'(cap_addr), 32'd5);
    check("t3_data", 32'(cap_data), 32'h1234);

    // Aborts in CMD: empty frame and a partial command byte
    frame(64'd0, 0);
    frame(64'(4'h8), 4);

    // Burst crossing the address wrap
    w0 = wr_cnt;
    frame(64'({8'h9F, 16'h1111, 16'h2222}), 40);
    if (AutoInc) begin
      check("t4_write_count", 32'(wr_cnt - w0), 32'd2);
      check("t4_addr", 32'(cap_addr), 32'd0);
      check("t4_data", 32'(cap_data), 32'h2222);
    end else begin
      check("t4_write_count", 32'(wr_cnt - w0), 32'd1);
      check("t4_addr", 32'(cap_addr), 32'd31);
      check("t4_data", 32'(cap_data), 32'h1111);
    end

    // One word plus trailing partial bits
    frame(64'({8'h82, 16'hBEEF, 5'h1B}), 29);

    // Reset mid-frame with cs_n held low
    w0 = wr_cnt;
    e0 = err_cnt;
    bus.spi_cs_n = 1'b0;
    tick(4);
    for (int i = 9; i >= 0; i--) spi_bit(i == 9 || i == 2);
    rst = 1'b0;
    tick(2);
    check("t5_instr_data", 32'(bus.instr_data), 32'd0);
    check("t5_write_addr", 32'(bus.write_addr), 32'd0);
    check("t5_write_en", 32'(bus.write_en), 32'd0);
    check("t5_busy", 32'(bus.busy), 32'd0);
    check("t5_frame_err", 32'(bus.frame_err), 32'd0);
    rst = 1'b1;
    tick(6);
    check("t5_busy_after_release", 32'(bus.busy), 32'd0);
    bus.spi_cs_n = 1'b1;
    tick(6);
    check("t5_no_write", 32'(wr_cnt - w0), 32'd0);
    check("t5_no_err", 32'(err_cnt - e0), 32'd0);
    frame(64'({8'h81, 16'h0001}), 24);
    check("t5_addr", 32'(cap_addr), 32'd1);
    check("t5_data", 32'(cap_data), 32'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
